ps2_scancode_receiver: RTL and testbench



---
 rtl/ps2_scancode_receiver.sv | 174 +++++++++++++++++
 tb/tb_ps2_scancode_receiver.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_receiver.sv
// PS/2 device-to-host receiver: synchronises and deglitches the pins, deframes 11-bit frames
// and emits each good byte as a one-cycle strobe with E0/F0 prefix qualifier flags.
module ps2_scancode_receiver #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  output logic [7:0] scancode,
  output logic       valid,
  output logic       break_flag,
  output logic       ext_flag,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int unsigned FiltW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TmoW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [FiltW-1:0] FiltLast = FiltW'(FILTER_LEN - 1);
  localparam logic [TmoW-1:0]  TmoLast  = TmoW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
  logic [FiltW-1:0]       filt_cnt_q, filt_cnt_d;
  logic                   filt_q, filt_d, filt_dly_q;
  state_e                 state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_q, par_d;
  logic [TmoW-1:0]        tmo_cnt_q, tmo_cnt_d, tmo_inc;
  logic                   pend_brk_q, pend_brk_d, pend_ext_q, pend_ext_d;
  logic [7:0]             scancode_q, scancode_d;
  logic                   valid_q, valid_d, brk_q, brk_d, ext_q, ext_d;
  logic                   perr_q, perr_d, ferr_q, ferr_d;
  logic                   clk_s, dat_s, fall;

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];
  assign fall  = filt_dly_q & ~filt_q;

  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clock};
    dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_data};

    // Any sample agreeing with the filtered value restarts the run count.
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_s != filt_q) begin
      if (filt_cnt_q == FiltLast) filt_d = clk_s;
      else                        filt_cnt_d = filt_cnt_q + 1'b1;
    end

    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    pend_brk_d = pend_brk_q;
    pend_ext_d = pend_ext_q;
    scancode_d = scancode_q;
    brk_d      = brk_q;
    ext_d      = ext_q;
    valid_d    = 1'b0;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;
    tmo_inc    = tmo_cnt_q + TmoW'(1);
    tmo_cnt_d  = (state_q == StIdle || fall) ? '0 : tmo_inc;

    if (state_q != StIdle && !fall && tmo_inc == TmoLast) begin
      state_d    = StIdle;
      ferr_d     = 1'b1;
      pend_brk_d = 1'b0;
      pend_ext_d = 1'b0;
      tmo_cnt_d  = '0;
    end else if (fall) begin
      unique case (state_q)
        StIdle: begin
          if (!dat_s) begin
            state_d   = StData;
            bit_cnt_d = 3'd0;
          end
        end
        StData: begin
          shift_d   = {dat_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          par_d   = dat_s;
          state_d = StStop;
        end
        StStop: begin
          state_d = StIdle;
          if (dat_s && (^shift_q ^ par_q)) begin
            valid_d    = 1'b1;
            scancode_d = shift_q;
            brk_d      = 1'b0;
            ext_d      = 1'b0;
            if (shift_q == 8'hF0) begin
              pend_brk_d = 1'b1;
            end else if (shift_q == 8'hE0) begin
              pend_ext_d = 1'b1;
            end else begin
              brk_d      = pend_brk_q;
              ext_d      = pend_ext_q;
              pend_brk_d = 1'b0;
              pend_ext_d = 1'b0;
            end
          end else begin
            // Bad stop outranks bad parity.
            perr_d     = dat_s;
            ferr_d     = ~dat_s;
            pend_brk_d = 1'b0;
            pend_ext_d = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      filt_cnt_q <= '0;
      filt_q     <= 1'b1;
      filt_dly_q <= 1'b1;
      state_q    <= StIdle;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      par_q      <= 1'b0;
      tmo_cnt_q  <= '0;
      pend_brk_q <= 1'b0;
      pend_ext_q <= 1'b0;
      scancode_q <= 8'h00;
      valid_q    <= 1'b0;
      brk_q      <= 1'b0;
      ext_q      <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      filt_cnt_q <= filt_cnt_d;
      filt_q     <= filt_d;
      filt_dly_q <= filt_q;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tmo_cnt_q  <= tmo_cnt_d;
      pend_brk_q <= pend_brk_d;
      pend_ext_q <= pend_ext_d;
      scancode_q <= scancode_d;
      valid_q    <= valid_d;
      brk_q      <= brk_d;
      ext_q      <= ext_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  assign scancode   = scancode_q;
  assign valid      = valid_q;
  assign break_flag = brk_q;
  assign ext_flag   = ext_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Directed bench for ps2_scancode_receiver: frames, prefixes, errors, timeout, glitches, reset.
module tb_ps2_scancode_receiver;

  localparam int unsigned SyncStages    = 2;
  localparam int unsigned FilterLen     = 4;
  localparam int unsigned TimeoutCycles = 200;
  localparam int unsigned Half          = 20;  // shortened PS/2 half-period to keep the run short
  localparam int unsigned Lat           = SyncStages + FilterLen + 1;

  logic       clk_in = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clock = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] scancode;
  logic       valid, break_flag, ext_flag, parity_err, frame_err;

  ps2_scancode_receiver #(
    .SYNC_STAGES   (SyncStages),
    .FILTER_LEN    (FilterLen),
    .TIMEOUT_CYCLES(TimeoutCycles)
  ) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .ps2_clock (ps2_clock),
    .ps2_data  (ps2_data),
    .scancode  (scancode),
    .valid     (valid),
    .break_flag(break_flag),
    .ext_flag  (ext_flag),
    .parity_err(parity_err),
    .frame_err (frame_err)
  );

  always #10 clk_in = ~clk_in;

  int unsigned cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int unsigned n_valid = 0, n_perr = 0, n_ferr = 0, n_overlap = 0;
  int unsigned t_valid = 0, t_ferr = 0;
  logic [7:0]  cap_code = 8'h00;
  logic        cap_brk = 1'b0, cap_ext = 1'b0;

  always @(negedge clk_in) begin
    if (valid) begin
      n_valid++;
      t_valid = cyc;
      cap_code = scancode;
      cap_brk = break_flag;
      cap_ext = ext_flag;
    end
    if (parity_err) n_perr++;
    if (frame_err) begin
      n_ferr++;
      t_ferr = cyc;
    end
    if (int'(valid) + int'(parity_err) + int'(frame_err) > 1) n_overlap++;
  end

  int unsigned n_vec = 0, n_err = 0;
  int unsigned s_valid, s_perr, s_ferr, last_fall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic mark();
    s_valid = n_valid;
    s_perr  = n_perr;
    s_ferr  = n_ferr;
  endtask

  task automatic check_counts(input string tag, input int unsigned v, input int unsigned p,
                              input int unsigned f);
    check({tag, ".nvalid"}, 32'(n_valid - s_valid), 32'(v));
    check({tag, ".nperr"}, 32'(n_perr - s_perr), 32'(p));
    check({tag, ".nferr"}, 32'(n_ferr - s_ferr), 32'(f));
  endtask

  // Optional 2-cycle low glitch in the clock-high phase before the falling edge.
  task automatic send_bit(input logic b, input logic glitch);
    ps2_data = b;
    if (glitch) begin
      tick(6);
      ps2_clock = 1'b0;
      tick(2);
      ps2_clock = 1'b1;
      tick(Half - 8);
    end else begin
      tick(Half);
    end
    ps2_clock = 1'b0;
    last_fall = cyc;
    tick(Half);
    ps2_clock = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_ok, input logic stop,
                            input int glitch_bit);
    logic [10:0] f;
    f = {stop, par_ok ? ~^b : ^b, b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(f[i], i == glitch_bit);
    ps2_data = 1'b1;
    tick(Lat + 4);
  endtask

  task automatic frame_ok(input string tag, input logic [7:0] b, input logic brk,
                          input logic ext, input int glitch_bit);
    mark();
    send_frame(b, 1'b1, 1'b1, glitch_bit);
    check_counts(tag, 1, 0, 0);
    check({tag, ".code"}, 32'(cap_code), 32'(b));
    check({tag, ".brk"}, 32'(cap_brk), 32'(brk));
    check({tag, ".ext"}, 32'(cap_ext), 32'(ext));
  endtask

  initial begin
    tick(3);
    check("rst.code", 32'(scancode), 32'h00);
    check("rst.valid", 32'(valid), 32'h0);
    check("rst.brk", 32'(break_flag), 32'h0);
    check("rst.ext", 32'(ext_flag), 32'h0);
    check("rst.perr", 32'(parity_err), 32'h0);
    check("rst.ferr", 32'(frame_err), 32'h0);
    reset = 1'b0;
    tick(5);

    frame_ok("f1c", 8'h1C, 1'b0, 1'b0, -1);
    check("f1c.latency", 32'(t_valid - last_fall), 32'(Lat));
    check("f1c.hold", 32'(scancode), 32'h1C);

    frame_ok("brk.f0", 8'hF0, 1'b0, 1'b0, -1);
    frame_ok("brk.1c", 8'h1C, 1'b1, 1'b0, -1);
    frame_ok("brk.1c2", 8'h1C, 1'b0, 1'b0, -1);

    frame_ok("ext.e0", 8'hE0, 1'b0, 1'b0, -1);
    frame_ok("ext.f0", 8'hF0, 1'b0, 1'b0, -1);
    frame_ok("ext.75", 8'h75, 1'b1, 1'b1, -1);

    mark();
    send_frame(8'h5A, 1'b0, 1'b1, -1);
    check_counts("par5a", 0, 1, 0);
    check("par5a.code", 32'(scancode), 32'h75);
    check("par5a.brk", 32'(break_flag), 32'h1);
    check("par5a.t", 32'(n_perr - s_perr), 32'h1);
    mark();
    send_frame(8'hE0, 1'b1, 1'b0, -1);
    check_counts("stope0", 0, 0, 1);
    frame_ok("after.29", 8'h29, 1'b0, 1'b0, -1);

    frame_ok("pend.e0", 8'hE0, 1'b0, 1'b0, -1);
    mark();
    send_frame(8'h5A, 1'b0, 1'b1, -1);
    check_counts("pend.perr", 0, 1, 0);
    frame_ok("pend.29", 8'h29, 1'b0, 1'b0, -1);

    mark();
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    tick(TimeoutCycles + Lat + 20);
    check_counts("tmo", 0, 0, 1);
    check("tmo.when", 32'(t_ferr - last_fall), 32'(Lat + TimeoutCycles - 1));
    frame_ok("tmo.1c", 8'h1C, 1'b0, 1'b0, -1);

    mark();
    ps2_clock = 1'b0;
    tick(2);
    ps2_clock = 1'b1;
    tick(30);
    check_counts("glitch.idle", 0, 0, 0);
    frame_ok("glitch.3a", 8'h3A, 1'b0, 1'b0, 4);

    frame_ok("rst.f0", 8'hF0, 1'b0, 1'b0, -1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    reset = 1'b1;
    ps2_data = 1'b1;
    tick(1);
    check("midrst.code", 32'(scancode), 32'h00);
    check("midrst.flags", 32'({valid, break_flag, ext_flag, parity_err, frame_err}), 32'h0);
    tick(2);
    reset = 1'b0;
    tick(5);
    frame_ok("midrst.45", 8'h45, 1'b0, 1'b0, -1);

    check("overlap", 32'(n_overlap), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
